// File: rtl/ncsi_avmm_csr_master.sv
// NC-SI CSR request to Avalon-MM master bridge: single read/write with read timeout.
// Optional poll-until-match reads are compiled in only when NCSI_AVMM_POLL_EN is defined.
module ncsi_avmm_csr_master #(
   parameter int unsigned RD_TIMEOUT = 256,
   parameter int unsigned POLL_MAX   = 1024,
   parameter int unsigned POLL_GAP   = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [8:0]  req_addr,
   input  logic [63:0] req_wrdata,
   input  logic [7:0]  req_byteen,
   input  logic [63:0] req_mask,
   output logic        resp_valid,
   output logic [63:0] resp_rddata,
   output logic [1:0]  resp_status,
   output logic [8:0]  m_addr,
   output logic        m_write,
   output logic        m_read,
   output logic [63:0] m_wrdata,
   output logic [7:0]  m_byteen,
   input  logic [63:0] m_rddata,
   input  logic        m_rddvld,
   input  logic        m_waitreq
);
   localparam int unsigned CNT_MAX = (RD_TIMEOUT > POLL_GAP) ? RD_TIMEOUT : POLL_GAP;
   localparam int unsigned CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] RD_LAST = CW'(RD_TIMEOUT - 1);
   localparam logic [1:0]  ST_OK       = 2'd0;
   localparam logic [1:0]  ST_TIMEOUT  = 2'd1;
   localparam logic [1:0]  ST_POLL_EXH = 2'd2;
   localparam logic [1:0]  ST_ILLEGAL  = 2'd3;
   localparam logic [63:0] TIMEOUT_DATA = 64'hBAADBEEF_DEADBEEF;

   typedef enum logic [2:0] {
      IDLE, WR, RD, RDWAIT,
`ifdef NCSI_AVMM_POLL_EN
      GAP,
`endif
      RESP
   } state_t;

   state_t         state_q, state_d;
   logic [8:0]     addr_q, addr_d;
   logic [63:0]    wrdata_q, wrdata_d;
   logic [7:0]     byteen_q, byteen_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [63:0]    rddata_q, rddata_d;
   logic [1:0]     status_q, status_d;

`ifdef NCSI_AVMM_POLL_EN
   localparam int unsigned AW = $clog2(POLL_MAX + 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(POLL_GAP - 1);
   localparam logic [AW-1:0] ATT_LAST = AW'(POLL_MAX - 1);
   logic           poll_q, poll_d;
   logic [63:0]    mask_q, mask_d;
   logic [AW-1:0]  att_q, att_d;
   logic           match;
   // req_wrdata doubles as the poll expected value
   assign match = ((m_rddata & mask_q) == (wrdata_q & mask_q));
`else
   logic unused_mask;
   assign unused_mask = ^req_mask;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wrdata_q <= '0;
         byteen_q <= '0;
         cnt_q    <= '0;
         rddata_q <= '0;
         status_q <= '0;
`ifdef NCSI_AVMM_POLL_EN
         poll_q   <= 1'b0;
         mask_q   <= '0;
         att_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wrdata_q <= wrdata_d;
         byteen_q <= byteen_d;
         cnt_q    <= cnt_d;
         rddata_q <= rddata_d;
         status_q <= status_d;
`ifdef NCSI_AVMM_POLL_EN
         poll_q   <= poll_d;
         mask_q   <= mask_d;
         att_q    <= att_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wrdata_d = wrdata_q;
      byteen_d = byteen_q;
      cnt_d    = cnt_q;
      rddata_d = rddata_q;
      status_d = status_q;
`ifdef NCSI_AVMM_POLL_EN
      poll_d   = poll_q;
      mask_d   = mask_q;
      att_d    = att_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               wrdata_d = req_wrdata;
               byteen_d = req_byteen;
`ifdef NCSI_AVMM_POLL_EN
               poll_d   = 1'b0;
`endif
               case (req_op)
                  2'd0: state_d = RD;
                  2'd1: state_d = WR;
`ifdef NCSI_AVMM_POLL_EN
                  2'd2: begin
                     state_d = RD;
                     poll_d  = 1'b1;
                     mask_d  = req_mask;
                     att_d   = '0;
                  end
`endif
                  default: begin
                     state_d  = RESP;
                     status_d = ST_ILLEGAL;
                     rddata_d = '0;
                  end
               endcase
            end
         end
         WR: begin
            if (!m_waitreq) begin
               state_d  = RESP;
               status_d = ST_OK;
               rddata_d = '0;
            end
         end
         RD: begin
            if (!m_waitreq) begin
               state_d = RDWAIT;
               cnt_d   = '0;
            end
         end
         RDWAIT: begin
            if (m_rddvld) begin
               state_d  = RESP;
               status_d = ST_OK;
               rddata_d = m_rddata;
`ifdef NCSI_AVMM_POLL_EN
               if (poll_q && !match) begin
                  att_d = att_q + 1'b1;
                  if (att_q == ATT_LAST) begin
                     status_d = ST_POLL_EXH;
                  end else begin
                     state_d = GAP;
                     cnt_d   = '0;
                  end
               end
`endif
            end else if (cnt_q == RD_LAST) begin
               state_d  = RESP;
               status_d = ST_TIMEOUT;
               rddata_d = TIMEOUT_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef NCSI_AVMM_POLL_EN
         GAP: begin
            if (cnt_q == GAP_LAST) state_d = RD;
            else                   cnt_d   = cnt_q + 1'b1;
         end
`endif
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign req_ready   = (state_q == IDLE);
   assign resp_valid  = (state_q == RESP);
   assign resp_rddata = rddata_q;
   assign resp_status = status_q;
   assign m_write     = (state_q == WR);
   assign m_read      = (state_q == RD);
   assign m_addr      = addr_q;
   assign m_wrdata    = wrdata_q;
   assign m_byteen    = byteen_q;

endmodule

// File: tb/tb_ncsi_avmm_csr_master.sv
// Self-checking bench for ncsi_avmm_csr_master: directed cases plus randomized read/write
// traffic against a memory-array reference; poll cases depend on NCSI_AVMM_POLL_EN.
module tb_ncsi_avmm_csr_master;
   localparam int unsigned RD_TO = 8;
   localparam int unsigned P_MAX = 4;
   localparam int unsigned P_GAP = 3;
   localparam logic [63:0] TO_DATA = 64'hBAADBEEF_DEADBEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [8:0]  req_addr;
   logic [63:0] req_wrdata, req_mask;
   logic [7:0]  req_byteen;
   logic        resp_valid;
   logic [63:0] resp_rddata;
   logic [1:0]  resp_status;
   logic [8:0]  m_addr;
   logic        m_write, m_read;
   logic [63:0] m_wrdata, m_rddata;
   logic [7:0]  m_byteen;
   logic        m_rddvld, m_waitreq;

   ncsi_avmm_csr_master #(.RD_TIMEOUT(RD_TO), .POLL_MAX(P_MAX), .POLL_GAP(P_GAP)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
      .req_wrdata(req_wrdata), .req_byteen(req_byteen), .req_mask(req_mask),
      .resp_valid(resp_valid), .resp_rddata(resp_rddata), .resp_status(resp_status),
      .m_addr(m_addr), .m_write(m_write), .m_read(m_read), .m_wrdata(m_wrdata),
      .m_byteen(m_byteen), .m_rddata(m_rddata), .m_rddvld(m_rddvld), .m_waitreq(m_waitreq)
   );

   initial forever #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit [63:0] merge(input bit [63:0] old, input bit [63:0] data, input bit [7:0] be);
      bit [63:0] r = old;
      for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = data[b*8 +: 8];
      return r;
   endfunction

   // Avalon slave model: wait-states, read latency (0 = never answers), optional data override
   bit [63:0]   slv_mem [512];
   bit [63:0]   ref_mem [512];
   logic [63:0] ovr_q[$];
   int          gaps[$];
   int ws_cfg = 0, lat_cfg = 1, ws_left = 0, hold = 0, last_hold = 0, pend = 0, cyc = 0;
   int last_dvld_cyc = 0, resp_cnt = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0, unstable = 0;
   logic        prev_rd = 1'b0;
   logic [63:0] pend_data = '0;
   logic [82:0] snap = '0;

   initial begin
      m_waitreq = 1'b1; m_rddvld = 1'b0; m_rddata = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (resp_valid) resp_cnt++;
         if (m_read && m_write) both_cnt++;
         m_rddvld = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               m_rddvld = 1'b1; m_rddata = pend_data; last_dvld_cyc = cyc;
            end
         end
         if (m_read && !prev_rd) gaps.push_back(cyc - last_dvld_cyc - 1);
         prev_rd = m_read;
         if (m_read || m_write) begin
            if (hold == 0) begin
               ws_left = ws_cfg;
               snap = {m_addr, m_wrdata, m_byteen, m_read, m_write};
            end else if (snap != {m_addr, m_wrdata, m_byteen, m_read, m_write}) unstable++;
            hold++;
            if (ws_left > 0) begin
               m_waitreq = 1'b1; ws_left--;
            end else begin
               m_waitreq = 1'b0; last_hold = hold; hold = 0;
               if (m_write) begin
                  slv_mem[m_addr] = merge(slv_mem[m_addr], m_wrdata, m_byteen);
                  wr_cnt++;
               end else begin
                  rd_cnt++;
                  pend_data = (ovr_q.size() > 0) ? ovr_q.pop_front() : slv_mem[m_addr];
                  pend = lat_cfg;
               end
            end
         end else begin
            m_waitreq = 1'b1; hold = 0;
         end
      end
   end

   task automatic run_req(input logic [1:0] op, input logic [8:0] addr, input logic [63:0] data,
                          input logic [7:0] be, input logic [63:0] mask, input int ws, input int lat,
                          output logic [1:0] st, output logic [63:0] rd, output int lat_o,
                          output int n_resp, output int n_rd, output int n_wr);
      int r0, rd0, wr0, w;
      @(negedge clk); #1;
      ws_cfg = ws; lat_cfg = lat;
      r0 = resp_cnt; rd0 = rd_cnt; wr0 = wr_cnt;
      req_op = op; req_addr = addr; req_wrdata = data; req_byteen = be; req_mask = mask;
      req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 50) begin @(negedge clk); #1; w++; end
      check("req_accept", req_ready, 1);
      @(negedge clk);
      req_valid = 1'b0;
      lat_o = 1;
      while (!resp_valid && lat_o < 200) begin @(negedge clk); lat_o++; end
      check("resp_seen", resp_valid, 1);
      st = resp_status; rd = resp_rddata;
      @(negedge clk); #1;
      check("resp_one_cycle", resp_valid, 0);
      n_resp = resp_cnt - r0; n_rd = rd_cnt - rd0; n_wr = wr_cnt - wr0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  st;
      logic [63:0] rd, d, last;
      int lat, nr, nrd, nwr, r0, ws, rl, sel;
      logic [8:0] a;
      logic [7:0] be;

      reset = 1'b1; req_valid = 1'b0; req_op = '0; req_addr = '0;
      req_wrdata = '0; req_byteen = '0; req_mask = '0;
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      #1;
      check("rst_req_ready", req_ready, 1);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_m_read", m_read, 0);
      check("rst_m_write", m_write, 0);
      check("rst_m_addr", m_addr, 0);
      check("rst_m_wrdata", m_wrdata, 0);
      check("rst_m_byteen", m_byteen, 0);
      check("rst_resp_rddata", resp_rddata, 0);
      check("rst_resp_status", resp_status, 0);

      // write with three wait-states
      run_req(2'd1, 9'h10, 64'h400000AB, 8'hFF, '0, 3, 1, st, rd, lat, nr, nrd, nwr);
      ref_mem[9'h10] = merge(ref_mem[9'h10], 64'h400000AB, 8'hFF);
      check("wr_ws_status", st, 0);
      check("wr_ws_rddata", rd, 0);
      check("wr_ws_hold", last_hold, 4);
      check("wr_ws_nresp", nr, 1);
      check("wr_ws_nwr", nwr, 1);
      check("wr_ws_mem", slv_mem[9'h10], ref_mem[9'h10]);

      // zero-wait write: response in the third cycle counting the request cycle
      run_req(2'd1, 9'h20, 64'h1122334455667788, 8'h5A, '0, 0, 1, st, rd, lat, nr, nrd, nwr);
      ref_mem[9'h20] = merge(ref_mem[9'h20], 64'h1122334455667788, 8'h5A);
      check("wr_min_latency", lat, 2);
      check("wr_be_mem", slv_mem[9'h20], ref_mem[9'h20]);

      ovr_q.push_back(64'h3010_0000_1000_1023);
      run_req(2'd0, 9'h0, '0, '0, '0, 0, 2, st, rd, lat, nr, nrd, nwr);
      check("rd_lat2_status", st, 0);
      check("rd_lat2_data", rd, 64'h3010_0000_1000_1023);
      check("rd_lat2_nrd", nrd, 1);

      run_req(2'd0, 9'h10, '0, '0, '0, 1, RD_TO, st, rd, lat, nr, nrd, nwr);
      check("rd_edge_status", st, 0);
      check("rd_edge_data", rd, ref_mem[9'h10]);

      run_req(2'd0, 9'h10, '0, '0, '0, 0, RD_TO + 1, st, rd, lat, nr, nrd, nwr);
      check("rd_edge1_status", st, 1);
      check("rd_edge1_data", rd, TO_DATA);
      repeat (4) @(negedge clk);

      // late data after timeout must not produce a second response
      run_req(2'd0, 9'h20, '0, '0, '0, 0, RD_TO + 4, st, rd, lat, nr, nrd, nwr);
      check("rd_to_status", st, 1);
      check("rd_to_data", rd, TO_DATA);
      r0 = resp_cnt;
      repeat (8) @(negedge clk);
      #1 check("rd_late_ignored", resp_cnt - r0, 0);
      run_req(2'd0, 9'h20, '0, '0, '0, 0, 1, st, rd, lat, nr, nrd, nwr);
      check("rd_after_late", rd, ref_mem[9'h20]);

      run_req(2'd3, 9'h10, 64'hFFFF, 8'hFF, '0, 0, 1, st, rd, lat, nr, nrd, nwr);
      check("op3_status", st, 3);
      check("op3_nbus", nrd + nwr, 0);

`ifdef NCSI_AVMM_POLL_EN
      gaps.delete();
      ovr_q.push_back(64'h0);
      ovr_q.push_back(64'h7FFF_FFFF_FFFF_FFFF);
      ovr_q.push_back(64'h8000_0000_0000_0055);
      run_req(2'd2, 9'h30, 64'h8000_0000_0000_0000, '0, 64'h8000_0000_0000_0000, 0, 2,
              st, rd, lat, nr, nrd, nwr);
      check("poll_ok_status", st, 0);
      check("poll_ok_data", rd, 64'h8000_0000_0000_0055);
      check("poll_ok_nrd", nrd, 3);
      check("poll_gap1", (gaps.size() > 1) ? gaps[1] : -1, P_GAP);
      check("poll_gap2", (gaps.size() > 2) ? gaps[2] : -1, P_GAP);

      ovr_q.delete();
      for (int i = 0; i < int'(P_MAX); i++) begin
         d = {$urandom, $urandom};
         d[63] = 1'b0;
         ovr_q.push_back(d);
         last = d;
      end
      run_req(2'd2, 9'h31, 64'h8000_0000_0000_0000, '0, 64'h8000_0000_0000_0000, 1, 3,
              st, rd, lat, nr, nrd, nwr);
      check("poll_exh_status", st, 2);
      check("poll_exh_data", rd, last);
      check("poll_exh_nrd", nrd, P_MAX);
      ovr_q.delete();
`else
      run_req(2'd2, 9'h30, 64'h1, '0, 64'h1, 0, 2, st, rd, lat, nr, nrd, nwr);
      check("op2_illegal_status", st, 3);
      check("op2_nrd", nrd, 0);
`endif

      // reset while waiting for read data
      @(negedge clk); #1;
      ws_cfg = 0; lat_cfg = 0; r0 = resp_cnt;
      req_op = 2'd0; req_addr = 9'h10; req_valid = 1'b1;
      @(negedge clk); req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      check("rst_mid_busy", req_ready, 0);
      reset = 1'b1;
      #1;
      check("rst_mid_async_ready", req_ready, 1);
      check("rst_mid_m_read", m_read, 0);
      @(negedge clk);
      check("rst_mid_resp_valid", resp_valid, 0);
      #1 reset = 1'b0;
      repeat (RD_TO + 4) @(negedge clk);
      #1 check("rst_mid_no_resp", resp_cnt - r0, 0);
      run_req(2'd0, 9'h10, '0, '0, '0, 0, 3, st, rd, lat, nr, nrd, nwr);
      check("rst_next_status", st, 0);
      check("rst_next_data", rd, ref_mem[9'h10]);

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         a   = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 7));
         d   = {$urandom, $urandom};
         be  = 8'($urandom_range(0, 255));
         ws  = $urandom_range(0, 3);
         rl  = $urandom_range(1, RD_TO + 3);
`ifdef NCSI_AVMM_POLL_EN
         if (sel == 9) sel = 0;
`endif
         if (sel <= 3) begin
            run_req(2'd0, a, d, be, '0, ws, rl, st, rd, lat, nr, nrd, nwr);
            check("rnd_rd_status", st, (rl <= int'(RD_TO)) ? 0 : 1);
            check("rnd_rd_data", rd, (rl <= int'(RD_TO)) ? ref_mem[a] : TO_DATA);
            check("rnd_rd_hold", last_hold, ws + 1);
            check("rnd_rd_nrd", nrd, 1);
            if (rl > int'(RD_TO)) repeat (6) @(negedge clk);
         end else if (sel <= 7) begin
            run_req(2'd1, a, d, be, '0, ws, rl, st, rd, lat, nr, nrd, nwr);
            ref_mem[a] = merge(ref_mem[a], d, be);
            check("rnd_wr_status", st, 0);
            check("rnd_wr_rddata", rd, 0);
            check("rnd_wr_hold", last_hold, ws + 1);
            check("rnd_wr_mem", slv_mem[a], ref_mem[a]);
         end else begin
            run_req(2'(sel == 8 ? 3 : 2), a, d, be, d, ws, rl, st, rd, lat, nr, nrd, nwr);
            check("rnd_ill_status", st, 3);
            check("rnd_ill_nbus", nrd + nwr, 0);
         end
         check("rnd_nresp", nr, 1);
      end

      check("never_rd_and_wr", both_cnt, 0);
      check("cmd_stable", unstable, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ncsi_avmm_csr_master.md
NCSI_AVMM_CSR_MASTER -- requirements
Module: ncsi_avmm_csr_master

Interface
REQ-001 SHALL have parameter RD_TIMEOUT, default 256, max cycles from read command acceptance to m_rddvld.
REQ-002 SHALL have parameter POLL_MAX, default 1024, max read attempts per poll request.
REQ-003 SHALL have parameter POLL_GAP, default 16, idle cycles between poll reads (min 1).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports req_valid input 1, req_ready output 1: request handshake.
REQ-007 SHALL have port req_op  input  2  0=read, 1=write, 2=poll, 3=illegal.
REQ-008 SHALL have ports req_addr input 9, req_wrdata input 64, req_byteen input 8, req_mask input 64: qword address, write data or poll expected value, byte enables, poll compare mask.
REQ-009 SHALL have ports resp_valid output 1, resp_rddata output 64, resp_status output 2 (0=OK, 1=timeout, 2=poll exhausted, 3=illegal op).
REQ-010 SHALL have AVMM master ports m_addr output 9, m_write output 1, m_read output 1, m_wrdata output 64, m_byteen output 8, m_rddata input 64, m_rddvld input 1, m_waitreq input 1.

Function
REQ-011 SHALL implement FSM states IDLE, WR, RD, RDWAIT, GAP, RESP; req_ready=1 only in IDLE.
REQ-012 SHALL capture req_* on req_valid&&req_ready; op0->RD, op1->WR, op2->RD (poll), op3->RESP with status 3, no bus access.
REQ-013 SHALL in WR/RD drive m_write/m_read=1 with captured addr/data/byteen, held stable until a cycle with m_waitreq=0.
REQ-014 SHALL on write acceptance (m_write&&!m_waitreq) go to RESP, status 0, resp_rddata 0.
REQ-015 SHALL on read acceptance go to RDWAIT, clear timeout counter, deassert m_read next cycle.
REQ-016 SHALL in RDWAIT increment the counter each cycle; m_rddvld for a read op -> RESP, status 0, resp_rddata=m_rddata.
REQ-017 SHALL on counter reaching RD_TIMEOUT without m_rddvld -> RESP, status 1, resp_rddata=64'hBAADBEEF_DEADBEEF.
REQ-018 SHALL for poll on m_rddvld: if (m_rddata&req_mask)==(req_wrdata&req_mask) -> RESP status 0 with m_rddata; else increment attempt count.
REQ-019 SHALL on attempt count==POLL_MAX -> RESP status 2 with last m_rddata; else GAP for POLL_GAP cycles then RD.
REQ-020 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; minimum request-to-response latency 3 cycles (write, no wait-states).
REQ-021 SHALL ignore m_rddvld outside RDWAIT, including late data after a timeout.
REQ-022 SHALL never assert m_read and m_write together; at most one outstanding read.

Reset
REQ-023 SHALL on reset go to IDLE; req_ready=1 after release, resp_valid, m_read, m_write=0, m_addr, m_wrdata, m_byteen, resp_rddata, resp_status, counters=0.
REQ-024 SHALL on reset mid-transaction abandon it with no response; next request is served normally.

Configuration
REQ-025 SHALL compile poll support only when macro NCSI_AVMM_POLL_EN is defined.
REQ-026 SHALL with NCSI_AVMM_POLL_EN defined implement REQ-018/019 and the GAP state.
REQ-027 SHALL without NCSI_AVMM_POLL_EN treat req_op=2 as illegal (status 3, no bus access); GAP state, attempt counter, req_mask logic absent.

Verification
REQ-028 SHALL cover: write addr 0x10 data 0x400000AB byteen 0xFF, m_waitreq high 3 cycles -> m_write held 4 cycles, one resp_valid, status 0.
REQ-029 SHALL cover: read addr 0x0, m_rddvld 2 cycles after acceptance with 0x3010_0000_1000_1023 -> resp_rddata equal, status 0.
REQ-030 SHALL cover: read with no m_rddvld, RD_TIMEOUT=8 -> status 1, data 0xBAADBEEF_DEADBEEF; late m_rddvld afterwards ignored.
REQ-031 SHALL cover (POLL_EN): poll mask 0x8000_0000_0000_0000, expected same, bit 63 set on 3rd read -> 3 m_read pulses POLL_GAP apart, status 0.
REQ-032 SHALL cover (POLL_EN): POLL_MAX=4, never matching -> exactly 4 reads, status 2; without macro req_op=2 -> status 3, no m_read.
REQ-033 SHALL cover: reset asserted in RDWAIT -> no resp_valid, m_read=0; next read completes with status 0.
